// File: rtl/result_requant_drain_pkg.sv
// Shared widths, types and saturation helper for the result requantize/drain path.
package result_requant_drain_pkg;

   localparam int unsigned N_RES   = 16;
   localparam int unsigned ACC_W   = 32;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned SCALE_W = 16;
   localparam int unsigned SHIFT_W = 5;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned PROD_W  = ACC_W + SCALE_W + 1;
   // One guard bit so rounding/zero-point addition can never wrap
   localparam int unsigned SUM_W   = PROD_W + 1;

   localparam int Q_MIN = -128;
   localparam int Q_MAX = 127;

   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [OUT_W-1:0]  q_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [SUM_W-1:0]  sum_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Clamp a wide signed value into the int8 output range
   function automatic q_t sat_q(input sum_t v);
      q_t res;
      if (v > SUM_W'(Q_MAX)) begin
         res = q_t'(Q_MAX);
      end else if (v < SUM_W'(Q_MIN)) begin
         res = q_t'(Q_MIN);
      end else begin
         res = q_t'(v);
      end
      return res;
   endfunction

endpackage

// File: rtl/result_requant_drain_if.sv
// Byte stream toward the router/next layer: valid/ready with element index.
interface result_requant_drain_if;
   import result_requant_drain_pkg::*;

   q_t               out_data;
   logic [IDX_W-1:0] out_index;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_index, output out_valid, input out_ready);
   modport slave  (input out_data, input out_index, input out_valid, output out_ready);

endinterface

// File: rtl/result_requant_drain_requant_lane.sv
// Two-stage requantize pipe: S1 multiply, S2 round/shift/offset/saturate; whole pipe freezes on stall.
module result_requant_drain_requant_lane
   import result_requant_drain_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               in_valid_i,
   input  logic [IDX_W-1:0]   in_index_i,
   input  acc_t               acc_i,
   input  logic [SCALE_W-1:0] scale_i,
   input  logic [SHIFT_W-1:0] shift_i,
   input  q_t                 zp_i,
   output q_t                 out_data_o,
   output logic [IDX_W-1:0]   out_index_o,
   output logic               out_valid_o
);

   prod_t            prod_d;
   prod_t            prod_q;
   logic [IDX_W-1:0] idx1_q;
   logic             v1_q;
   q_t               data_d;
   q_t               data_q;
   logic [IDX_W-1:0] idx2_q;
   logic             v2_q;
   sum_t             rnd_c;
   sum_t             sum_c;
   sum_t             rsh_c;
   sum_t             val_c;

   // Signed accumulator times zero-extended unsigned scale
   always_comb begin
      prod_d = PROD_W'(acc_i) * PROD_W'($signed({1'b0, scale_i}));
   end

   // Round half toward +inf, arithmetic shift, add zero point, saturate
   always_comb begin
      rnd_c = '0;
      if (shift_i != '0) begin
         rnd_c = SUM_W'(1) <<< (shift_i - SHIFT_W'(1));
      end
      sum_c  = SUM_W'(prod_q) + rnd_c;
      rsh_c  = sum_c >>> shift_i;
      val_c  = rsh_c + SUM_W'(zp_i);
      data_d = sat_q(val_c);
   end

   // Stage 1 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         idx1_q <= '0;
         v1_q   <= 1'b0;
      end else if (!stall_i) begin
         v1_q <= in_valid_i;
         if (in_valid_i) begin
            prod_q <= prod_d;
            idx1_q <= in_index_i;
         end
      end
   end

   // Stage 2 (output) register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         idx2_q <= '0;
         v2_q   <= 1'b0;
      end else if (!stall_i) begin
         v2_q <= v1_q;
         if (v1_q) begin
            data_q <= data_d;
            idx2_q <= idx1_q;
         end
      end
   end

   assign out_data_o  = data_q;
   assign out_index_o = idx2_q;
   assign out_valid_o = v2_q;

endmodule

// File: rtl/result_requant_drain.sv
// Snapshot 16 accumulators on start, requantize to int8 and stream them out in index order.
module result_requant_drain
   import result_requant_drain_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [SCALE_W-1:0]     scale,
   input  logic [SHIFT_W-1:0]     shift,
   input  q_t                     zero_point,
   input  acc_t                   result_buffer [N_RES],
   result_requant_drain_if.master out_if,
   output logic                   busy,
   output logic                   done
);

   state_e             state_q;
   state_e             state_d;
   acc_t               snap_q [N_RES];
   logic [SCALE_W-1:0] scale_q;
   logic [SHIFT_W-1:0] shift_q;
   q_t                 zp_q;
   logic [CNT_W-1:0]   rd_cnt_q;
   logic [CNT_W-1:0]   rd_cnt_d;
   logic               busy_q;
   logic               busy_d;
   logic               done_q;
   logic               done_d;
   logic               capture_c;
   logic               issue_c;
   logic               stall_c;
   logic               last_hs_c;

   assign stall_c   = out_if.out_valid && !out_if.out_ready;
   assign last_hs_c = out_if.out_valid && out_if.out_ready
                      && (out_if.out_index == IDX_W'(N_RES - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_DRAIN;
         ST_DRAIN: if (last_hs_c) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      capture_c = 1'b0;
      issue_c   = 1'b0;
      rd_cnt_d  = rd_cnt_q;
      busy_d    = (state_d == ST_DRAIN);
      done_d    = (state_d == ST_DONE);
      if (state_q == ST_IDLE && start) begin
         capture_c = 1'b1;
         rd_cnt_d  = '0;
      end else if (state_q == ST_DRAIN && rd_cnt_q < CNT_W'(N_RES) && !stall_c) begin
         issue_c  = 1'b1;
         rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
   end

   // Registered control outputs and read index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Snapshot of accumulators and requant parameters at the accepted start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_RES; i++) begin
            snap_q[i] <= '0;
         end
         scale_q <= '0;
         shift_q <= '0;
         zp_q    <= '0;
      end else if (capture_c) begin
         snap_q  <= result_buffer;
         scale_q <= scale;
         shift_q <= shift;
         zp_q    <= zero_point;
      end
   end

   result_requant_drain_requant_lane u_lane (
      .clk         (clk),
      .rst_n       (reset),
      .stall_i     (stall_c),
      .in_valid_i  (issue_c),
      .in_index_i  (rd_cnt_q[IDX_W-1:0]),
      .acc_i       (snap_q[rd_cnt_q[IDX_W-1:0]]),
      .scale_i     (scale_q),
      .shift_i     (shift_q),
      .zp_i        (zp_q),
      .out_data_o  (out_if.out_data),
      .out_index_o (out_if.out_index),
      .out_valid_o (out_if.out_valid)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule
